lx32_mc_ctrl: RTL and testbench
===============================

Name: lx32_mc_ctrl

Overview:
- Multicycle control FSM for the lx32 non-pipelined core.
- Sequences fetch, decode, execute, memory and writeback over the shared datapath: PC, IR, imm_gen, ALU, register file and data memory port.
- Drives all datapath strobes and mux selects from its state and the opcode held in IR.
- Runs handshakes with the instruction and data memories, counts retired instructions, and traps on illegal opcodes.

Parameters:
- RET_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  7  instr[6:0] from IR output
- funct3_store  in  1  reserved, tie 0 (not used by this revision)
- imem_ack  in  1  instruction memory: read data valid this cycle
- dmem_ack  in  1  data memory: access complete this cycle
- branch_cond  in  1  ALU compare result for the current branch
- imem_req  out  1  instruction fetch request
- ir_we  out  1  IR load enable
- pc_we  out  1  PC write enable
- pc_sel  out  2  0=pc+4, 1=pc+imm, 2=alu_result&~1
- alu_a_sel  out  2  0=rs1, 1=pc, 2=zero
- alu_b_sel  out  1  0=rs2, 1=imm
- dmem_req  out  1  data memory request
- dmem_we  out  1  store when 1, load when 0 (valid only with dmem_req)
- rf_we  out  1  register file write enable
- wb_sel  out  2  0=alu, 1=mem rdata, 2=pc+4
- illegal  out  1  sticky illegal-opcode trap flag
- retired  out  RET_W  retired instruction count
- state_o  out  3  current state, debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Reset (rst=1 at a clock edge):
  - state=FETCH, retired=0, illegal=0.
  - While rst is high, all strobes are forced to 0: imem_req, ir_we, pc_we, dmem_req, dmem_we, rf_we.
  - While rst is high, all selects are 0.
  - Reset asserted mid-instruction aborts it: no pc_we or rf_we in that cycle, no retire.
- Outputs: combinational from state, the opcode input, and the acks. Any select not specified below is 0.
- FETCH:
  - imem_req=1.
  - imem_ack=1: ir_we=1, next state DECODE.
  - Otherwise stay in FETCH with req held.
  - Same-cycle ack is legal.
- DECODE: one cycle, so imm_gen settles on the new IR. Opcode not in the legal set goes to TRAP; otherwise to EXEC.
- Legal opcodes: OP 0110011, OP_IMM 0010011, LUI 0110111, AUIPC 0010111, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111.
- EXEC (one cycle), ALU selects per opcode:
  - OP: a=0, b=0.
  - OP_IMM, LOAD, STORE, JALR: a=0, b=1.
  - LUI: a=2, b=1.
  - AUIPC: a=1, b=1.
  - BRANCH: a=0, b=0.
- EXEC next state:
  - BRANCH: pc_we=1, pc_sel = branch_cond ? 1 : 0, retire, go to FETCH.
  - LOAD, STORE: go to MEM.
  - All others: go to WB.
- MEM:
  - dmem_req=1; dmem_we=1 iff opcode is STORE.
  - ALU selects stay as in EXEC (address must remain stable).
  - No dmem_ack: stay in MEM.
  - dmem_ack on STORE: pc_we=1, pc_sel=0, retire, go to FETCH.
  - dmem_ack on LOAD: go to WB.
- WB: rf_we=1, pc_we=1, retire, go to FETCH. Selects per opcode:
  - LOAD: wb_sel=1.
  - JAL: wb_sel=2, pc_sel=1.
  - JALR: wb_sel=2, pc_sel=2, ALU selects as in EXEC.
  - All others: wb_sel=0, pc_sel=0.
- TRAP:
  - illegal=1 and held, all strobes 0.
  - Absorbing state; only rst exits.
  - The illegal instruction is not retired.
- retired:
  - Increments by 1 on the retiring edge (the cycle pc_we=1 from EXEC, MEM or WB).
  - Wraps modulo 2^RET_W without flagging.
- Acks: imem_ack outside FETCH and dmem_ack outside MEM are ignored.
- Simultaneous rst and ack: reset wins; no ir_we.
- Cycle counts with zero-wait memories:
  - OP/OP_IMM/LUI/AUIPC/JAL/JALR: 4.
  - BRANCH: 3.
  - STORE: 4.
  - LOAD: 5.
  - Each memory wait cycle adds 1.

Test Plan:
- Reset, then opcode=0010011 with imem_ack tied 1 -> state_o sequence 0,1,2,4,0. rf_we=1 and pc_we=1 only in WB with wb_sel=0, pc_sel=0. retired=1 after 4 cycles.
- Hold imem_ack=0 for 3 cycles in FETCH -> imem_req stays 1 and ir_we stays 0. The ack cycle gives ir_we=1, then DECODE.
- LOAD 0000011 with dmem_ack delayed 2 cycles -> MEM held 3 cycles with dmem_req=1, dmem_we=0. WB then has wb_sel=1; total 7 cycles; retired increments once.
- STORE 0100011 -> MEM with dmem_we=1. On ack: pc_we=1, pc_sel=0, no rf_we, back to FETCH.
- BRANCH with branch_cond=1 then =0 -> EXEC pc_sel=1 then 0. rf_we never asserted; each takes 3 cycles.
- JAL 1101111 -> WB wb_sel=2, pc_sel=1. JALR 1100111 -> WB pc_sel=2, alu_b_sel=1.
- opcode=0000000 -> TRAP after DECODE. illegal=1 persists 10 cycles, retired unchanged, imem_req=0. rst=1 clears illegal and returns to FETCH.
- rst pulsed during MEM with dmem_ack=1 -> no pc_we, no retire; state 0 on the next cycle.
- RET_W=4: retire 16 instructions -> retired wraps to 0.

Source files
------------

// File: rtl/lx32_mc_ctrl.sv
// lx32_mc_ctrl - multicycle control FSM for the lx32 non-pipelined core.
//
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB over the
// shared datapath and drives every datapath strobe and mux select from the
// current state plus the opcode held in IR. Illegal opcodes park the FSM in
// TRAP until reset.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   opcode          instr[6:0] from the IR output
//   funct3_store    reserved, tie 0
//   imem_ack        instruction read data valid this cycle
//   dmem_ack        data access complete this cycle
//   branch_cond     ALU compare result for the current branch
//   imem_req/ir_we  instruction fetch request / IR load enable
//   pc_we/pc_sel    PC write enable / next-PC select (pc+4, pc+imm, alu&~1)
//   alu_a_sel       ALU operand A select (rs1, pc, zero)
//   alu_b_sel       ALU operand B select (rs2, imm)
//   dmem_req/we     data memory request / store (1) or load (0)
//   rf_we/wb_sel    register write enable / writeback source (alu, mem, pc+4)
//   illegal         sticky illegal-opcode trap flag
//   retired         retired instruction count, wraps silently
//   state_o         current state, debug
module lx32_mc_ctrl #(
    parameter int RET_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             funct3_store,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             branch_cond,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [1:0]       alu_a_sel,
    output logic             alu_b_sel,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             illegal,
    output logic [RET_W-1:0] retired,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    state_t     state;
    state_t     state_next;
    logic       opc_legal;
    logic [1:0] exec_a_sel;
    logic       exec_b_sel;
    logic       unused_inputs;

    // funct3_store is reserved for a later revision and has no effect here.
    assign unused_inputs = funct3_store;

    assign state_o = state;

    // Legality check and the ALU operand selects each opcode needs. The
    // selects are reused in MEM (address must stay stable) and in WB for
    // JALR (the jump target comes straight off the ALU).
    always_comb begin
        opc_legal  = 1'b1;
        exec_a_sel = 2'd0;
        exec_b_sel = 1'b0;
        case (opcode)
            OPC_OP:     begin exec_a_sel = 2'd0; exec_b_sel = 1'b0; end
            OPC_OP_IMM,
            OPC_LOAD,
            OPC_STORE,
            OPC_JALR:   begin exec_a_sel = 2'd0; exec_b_sel = 1'b1; end
            OPC_LUI:    begin exec_a_sel = 2'd2; exec_b_sel = 1'b1; end
            OPC_AUIPC:  begin exec_a_sel = 2'd1; exec_b_sel = 1'b1; end
            OPC_BRANCH: begin exec_a_sel = 2'd0; exec_b_sel = 1'b0; end
            OPC_JAL:    begin exec_a_sel = 2'd0; exec_b_sel = 1'b0; end
            default:    opc_legal = 1'b0;
        endcase
    end

    // Next-state and output decode. Everything defaults to 0 and stays 0
    // while rst is high, so a reset landing mid-instruction cannot leak a
    // PC or register write. Acks only matter in the state that waits on them.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 2'd0;
        alu_a_sel  = 2'd0;
        alu_b_sel  = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        rf_we      = 1'b0;
        wb_sel     = 2'd0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_we      = 1'b1;
                        state_next = DECODE;
                    end
                end
                DECODE: begin
                    state_next = opc_legal ? EXEC : TRAP;
                end
                EXEC: begin
                    alu_a_sel = exec_a_sel;
                    alu_b_sel = exec_b_sel;
                    if (opcode == OPC_BRANCH) begin
                        pc_we      = 1'b1;
                        pc_sel     = branch_cond ? 2'd1 : 2'd0;
                        state_next = FETCH;
                    end else if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
                        state_next = MEM;
                    end else begin
                        state_next = WB;
                    end
                end
                MEM: begin
                    alu_a_sel = exec_a_sel;
                    alu_b_sel = exec_b_sel;
                    dmem_req  = 1'b1;
                    dmem_we   = (opcode == OPC_STORE);
                    if (dmem_ack) begin
                        if (opcode == OPC_STORE) begin
                            pc_we      = 1'b1;
                            state_next = FETCH;
                        end else begin
                            state_next = WB;
                        end
                    end
                end
                WB: begin
                    rf_we      = 1'b1;
                    pc_we      = 1'b1;
                    state_next = FETCH;
                    case (opcode)
                        OPC_LOAD: wb_sel = 2'd1;
                        OPC_JAL: begin
                            wb_sel = 2'd2;
                            pc_sel = 2'd1;
                        end
                        OPC_JALR: begin
                            wb_sel    = 2'd2;
                            pc_sel    = 2'd2;
                            alu_a_sel = exec_a_sel;
                            alu_b_sel = exec_b_sel;
                        end
                        default: begin
                            wb_sel = 2'd0;
                            pc_sel = 2'd0;
                        end
                    endcase
                end
                TRAP: begin
                    state_next = TRAP;
                end
                default: begin
                    state_next = FETCH;
                end
            endcase
        end
    end

    // State register, retire counter and trap flag. Every instruction
    // retires on exactly the edge where it writes the PC, so pc_we doubles
    // as the retire strobe. The trap flag is set on the edge entering TRAP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            retired <= '0;
            illegal <= 1'b0;
        end else begin
            state <= state_next;
            if (pc_we) begin
                retired <= retired + RET_W'(1);
            end
            if (state_next == TRAP) begin
                illegal <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lx32_mc_ctrl.sv
// tb_lx32_mc_ctrl - directed self-checking bench for lx32_mc_ctrl.
//
// The DUT is built with a 4-bit retire counter so the wrap can be reached
// quickly. Each cycle the bench drives inputs just after the rising edge and
// compares a packed view of the control outputs on the falling edge against
// hand-computed vectors.
module tb_lx32_mc_ctrl;

    localparam int RET_W = 4;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BAD    = 7'b0000000;

    logic             clk;
    logic             rst;
    logic [6:0]       opcode;
    logic             funct3_store;
    logic             imem_ack;
    logic             dmem_ack;
    logic             branch_cond;
    logic             imem_req;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic [1:0]       alu_a_sel;
    logic             alu_b_sel;
    logic             dmem_req;
    logic             dmem_we;
    logic             rf_we;
    logic [1:0]       wb_sel;
    logic             illegal;
    logic [RET_W-1:0] retired;
    logic [2:0]       state_o;
    logic [15:0]      obs_vec;

    int check_count = 0;
    int fail_count  = 0;

    lx32_mc_ctrl #(.RET_W(RET_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .funct3_store (funct3_store),
        .imem_ack     (imem_ack),
        .dmem_ack     (dmem_ack),
        .branch_cond  (branch_cond),
        .imem_req     (imem_req),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .illegal      (illegal),
        .retired      (retired),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: state, imem_req, ir_we, pc_we, pc_sel, alu_a_sel,
    // alu_b_sel, dmem_req, dmem_we, rf_we, wb_sel.
    assign obs_vec = {state_o, imem_req, ir_we, pc_we, pc_sel, alu_a_sel,
                      alu_b_sel, dmem_req, dmem_we, rf_we, wb_sel};

    function automatic logic [15:0] ev(input logic [2:0] st,
                                       input logic ireq, input logic irwe,
                                       input logic pcwe, input logic [1:0] pcsel,
                                       input logic [1:0] asel, input logic bsel,
                                       input logic dreq, input logic dwe,
                                       input logic rfwe, input logic [1:0] wb);
        return {st, ireq, irwe, pcwe, pcsel, asel, bsel, dreq, dwe, rfwe, wb};
    endfunction

    // Single point of comparison: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs, check the control vector mid-cycle,
    // then advance to just past the next rising edge.
    task automatic applyStimulus(input string tag, input logic [6:0] opc,
                                 input logic ia, input logic da, input logic bc,
                                 input logic r, input logic [15:0] expv);
        opcode      = opc;
        imem_ack    = ia;
        dmem_ack    = da;
        branch_cond = bc;
        rst         = r;
        @(negedge clk);
        checkOutput(tag, 32'(obs_vec), 32'(expv));
        @(posedge clk);
        #1;
    endtask

    // Watchdog so the run always ends even if something stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        opcode       = OP;
        funct3_store = 1'b0;
        imem_ack     = 1'b0;
        dmem_ack     = 1'b0;
        branch_cond  = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset held with an ack present: nothing may be strobed.
        applyStimulus("rst_ack", OP, 1, 1, 1, 1, ev(0,0,0,0,0,0,0,0,0,0,0));
        checkOutput("rst_retired", 32'(retired), 32'd0);
        checkOutput("rst_illegal", 32'(illegal), 32'd0);

        // OP_IMM with zero-wait fetch: 0,1,2,4.
        applyStimulus("opi_fetch", OP_IMM, 1, 0, 0, 0, ev(0,1,1,0,0,0,0,0,0,0,0));
        applyStimulus("opi_dec",   OP_IMM, 1, 0, 0, 0, ev(1,0,0,0,0,0,0,0,0,0,0));
        applyStimulus("opi_exec",  OP_IMM, 1, 0, 0, 0, ev(2,0,0,0,0,0,1,0,0,0,0));
        applyStimulus("opi_wb",    OP_IMM, 1, 0, 0, 0, ev(4,0,0,1,0,0,0,0,0,1,0));
        checkOutput("opi_retired", 32'(retired), 32'd1);

        // OP with three fetch wait cycles.
        for (int i = 0; i < 3; i++)
            applyStimulus("op_fwait", OP, 0, 0, 0, 0, ev(0,1,0,0,0,0,0,0,0,0,0));
        applyStimulus("op_fetch", OP, 1, 0, 0, 0, ev(0,1,1,0,0,0,0,0,0,0,0));
        applyStimulus("op_dec",   OP, 0, 0, 0, 0, ev(1,0,0,0,0,0,0,0,0,0,0));
        applyStimulus("op_exec",  OP, 0, 0, 0, 0, ev(2,0,0,0,0,0,0,0,0,0,0));
        applyStimulus("op_wb",    OP, 0, 0, 0, 0, ev(4,0,0,1,0,0,0,0,0,1,0));
        checkOutput("op_retired", 32'(retired), 32'd2);

        // LOAD with two data wait cycles; stray dmem_ack in FETCH/DECODE ignored.
        applyStimulus("ld_fetch", LOAD, 1, 1, 0, 0, ev(0,1,1,0,0,0,0,0,0,0,0));
        applyStimulus("ld_dec",   LOAD, 0, 1, 0, 0, ev(1,0,0,0,0,0,0,0,0,0,0));
        applyStimulus("ld_exec",  LOAD, 0, 0, 0, 0, ev(2,0,0,0,0,0,1,0,0,0,0));
        applyStimulus("ld_mwait", LOAD, 0, 0, 0, 0, ev(3,0,0,0,0,0,1,1,0,0,0));
        applyStimulus("ld_mwait", LOAD, 0, 0, 0, 0, ev(3,0,0,0,0,0,1,1,0,0,0));
        checkOutput("ld_wait_retired", 32'(retired), 32'd2);
        applyStimulus("ld_mack",  LOAD, 0, 1, 0, 0, ev(3,0,0,0,0,0,1,1,0,0,0));
        applyStimulus("ld_wb",    LOAD, 0, 0, 0, 0, ev(4,0,0,1,0,0,0,0,0,1,1));
        checkOutput("ld_retired", 32'(retired), 32'd3);

        // STORE; stray imem_ack in MEM ignored.
        applyStimulus("st_fetch", STORE, 1, 0, 0, 0, ev(0,1,1,0,0,0,0,0,0,0,0));
        applyStimulus("st_dec",   STORE, 0, 0, 0, 0, ev(1,0,0,0,0,0,0,0,0,0,0));
        applyStimulus("st_exec",  STORE, 0, 0, 0, 0, ev(2,0,0,0,0,0,1,0,0,0,0));
        applyStimulus("st_mack",  STORE, 1, 1, 0, 0, ev(3,0,0,1,0,0,1,1,1,0,0));
        applyStimulus("st_next",  STORE, 0, 0, 0, 0, ev(0,1,0,0,0,0,0,0,0,0,0));
        checkOutput("st_retired", 32'(retired), 32'd4);

        // BRANCH taken then not taken.
        applyStimulus("bt_fetch", BRANCH, 1, 0, 1, 0, ev(0,1,1,0,0,0,0,0,0,0,0));
        applyStimulus("bt_dec",   BRANCH, 0, 0, 1, 0, ev(1,0,0,0,0,0,0,0,0,0,0));
        applyStimulus("bt_exec",  BRANCH, 0, 0, 1, 0, ev(2,0,0,1,1,0,0,0,0,0,0));
        checkOutput("bt_retired", 32'(retired), 32'd5);
        applyStimulus("bn_fetch", BRANCH, 1, 0, 0, 0, ev(0,1,1,0,0,0,0,0,0,0,0));
        applyStimulus("bn_dec",   BRANCH, 0, 0, 0, 0, ev(1,0,0,0,0,0,0,0,0,0,0));
        applyStimulus("bn_exec",  BRANCH, 0, 0, 0, 0, ev(2,0,0,1,0,0,0,0,0,0,0));
        checkOutput("bn_retired", 32'(retired), 32'd6);

        // JAL, JALR, LUI, AUIPC.
        applyStimulus("jal_fetch", JAL, 1, 0, 0, 0, ev(0,1,1,0,0,0,0,0,0,0,0));
        applyStimulus("jal_dec",   JAL, 0, 0, 0, 0, ev(1,0,0,0,0,0,0,0,0,0,0));
        applyStimulus("jal_exec",  JAL, 0, 0, 0, 0, ev(2,0,0,0,0,0,0,0,0,0,0));
        applyStimulus("jal_wb",    JAL, 0, 0, 0, 0, ev(4,0,0,1,1,0,0,0,0,1,2));
        applyStimulus("jalr_fetch", JALR, 1, 0, 0, 0, ev(0,1,1,0,0,0,0,0,0,0,0));
        applyStimulus("jalr_dec",   JALR, 0, 0, 0, 0, ev(1,0,0,0,0,0,0,0,0,0,0));
        applyStimulus("jalr_exec",  JALR, 0, 0, 0, 0, ev(2,0,0,0,0,0,1,0,0,0,0));
        applyStimulus("jalr_wb",    JALR, 0, 0, 0, 0, ev(4,0,0,1,2,0,1,0,0,1,2));
        applyStimulus("lui_fetch", LUI, 1, 0, 0, 0, ev(0,1,1,0,0,0,0,0,0,0,0));
        applyStimulus("lui_dec",   LUI, 0, 0, 0, 0, ev(1,0,0,0,0,0,0,0,0,0,0));
        applyStimulus("lui_exec",  LUI, 0, 0, 0, 0, ev(2,0,0,0,0,2,1,0,0,0,0));
        applyStimulus("lui_wb",    LUI, 0, 0, 0, 0, ev(4,0,0,1,0,0,0,0,0,1,0));
        applyStimulus("aui_fetch", AUIPC, 1, 0, 0, 0, ev(0,1,1,0,0,0,0,0,0,0,0));
        applyStimulus("aui_dec",   AUIPC, 0, 0, 0, 0, ev(1,0,0,0,0,0,0,0,0,0,0));
        applyStimulus("aui_exec",  AUIPC, 0, 0, 0, 0, ev(2,0,0,0,0,1,1,0,0,0,0));
        applyStimulus("aui_wb",    AUIPC, 0, 0, 0, 0, ev(4,0,0,1,0,0,0,0,0,1,0));
        checkOutput("jmp_retired", 32'(retired), 32'd10);

        // Reset during MEM with dmem_ack high aborts the store.
        applyStimulus("rm_fetch", STORE, 1, 0, 0, 0, ev(0,1,1,0,0,0,0,0,0,0,0));
        applyStimulus("rm_dec",   STORE, 0, 0, 0, 0, ev(1,0,0,0,0,0,0,0,0,0,0));
        applyStimulus("rm_exec",  STORE, 0, 0, 0, 0, ev(2,0,0,0,0,0,1,0,0,0,0));
        applyStimulus("rm_rst",   STORE, 0, 1, 0, 1, ev(3,0,0,0,0,0,0,0,0,0,0));
        checkOutput("rm_retired", 32'(retired), 32'd0);
        applyStimulus("rm_after", STORE, 0, 0, 0, 0, ev(0,1,0,0,0,0,0,0,0,0,0));

        // Sixteen branches wrap the 4-bit retire counter back to 0.
        for (int i = 0; i < 16; i++) begin
            applyStimulus("wrap_fetch", BRANCH, 1, 0, i[0], 0, ev(0,1,1,0,0,0,0,0,0,0,0));
            applyStimulus("wrap_dec",   BRANCH, 0, 0, i[0], 0, ev(1,0,0,0,0,0,0,0,0,0,0));
            applyStimulus("wrap_exec",  BRANCH, 0, 0, i[0], 0,
                          ev(2,0,0,1,{1'b0, i[0]},0,0,0,0,0,0));
            checkOutput("wrap_retired", 32'(retired), 32'((i + 1) % 16));
        end

        // Illegal opcode traps after DECODE and stays trapped.
        applyStimulus("il_fetch", BAD, 1, 0, 0, 0, ev(0,1,1,0,0,0,0,0,0,0,0));
        applyStimulus("il_dec",   BAD, 0, 0, 0, 0, ev(1,0,0,0,0,0,0,0,0,0,0));
        checkOutput("il_flag_set", 32'(illegal), 32'd1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus("il_trap", BAD, 1, 1, 1, 0, ev(5,0,0,0,0,0,0,0,0,0,0));
            checkOutput("il_flag_held", 32'(illegal), 32'd1);
        end
        checkOutput("il_retired", 32'(retired), 32'd0);
        applyStimulus("il_rst",   BAD, 0, 0, 0, 1, ev(5,0,0,0,0,0,0,0,0,0,0));
        checkOutput("il_flag_clr", 32'(illegal), 32'd0);
        applyStimulus("il_after", OP, 0, 0, 0, 0, ev(0,1,0,0,0,0,0,0,0,0,0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 check_count, fail_count);
        $finish;
    end

endmodule
